mips_network_interface: RTL and testbench

- Network interface (NI) between the pipelined MIPS core and its NoC router port.
- TX path: accepts single-word send requests from the core's execute stage, queues them, and serialises each into a 2-flit packet (head, tail) toward the router.
- RX path: reassembles incoming 2-flit packets and presents the 32-bit word to the core's register-write path, with a valid/ready handshake.

---
 rtl/mips_ni_pkg.sv | 24 ++
 rtl/ni_tx_fifo.sv | 70 +++++++
 rtl/mips_network_interface.sv | 220 ++++++++++++++++++++++
 tb/tb_mips_network_interface.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ni_pkg.sv
// Shared definitions for the MIPS network interface: flit types, flit field
// offsets and the TX/RX state encodings.
package mips_ni_pkg;

   // Flit type field values (top two bits of every flit)
   localparam logic [1:0] FLIT_HEAD = 2'b01;
   localparam logic [1:0] FLIT_TAIL = 2'b10;

   // Head flit payload layout
   localparam int HEAD_DEST_LSB = 0;
   localparam int HEAD_SRC_LSB  = 2;
   localparam int NODE_W        = 2;

   // TX FSM encodings
   localparam logic [1:0] T_IDLE = 2'd0;
   localparam logic [1:0] T_HEAD = 2'd1;
   localparam logic [1:0] T_TAIL = 2'd2;

   // RX FSM encodings
   localparam logic [1:0] R_HEAD = 2'd0;
   localparam logic [1:0] R_TAIL = 2'd1;
   localparam logic [1:0] R_HOLD = 2'd2;

endpackage

// File: rtl/ni_tx_fifo.sv
// First-word-fall-through request FIFO for the NI transmit path. Writes are
// dropped when full and reads are ignored when empty. The occupancy count is
// exported so the TX FSM can tell whether another packet follows a pop.
module ni_tx_fifo #(
   parameter int WIDTH = 34,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0] PTR_FULL = (AW+1)'(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign count   = wr_ptr_q - rd_ptr_q;
   assign full    = (count == PTR_FULL);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

   // Next pointer and storage values; the extra pointer bit separates full from empty
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (do_push) begin
         mem_d[wr_ptr_q[AW-1:0]] = wr_data;
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   // Pointer and storage registers, flushed on reset
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

endmodule

// File: rtl/mips_network_interface.sv
// Network interface between the MIPS core and its NoC router port.
// TX: queued single-word sends become head+tail packets. RX: head+tail packets
// are reassembled into one word handed to the core with a valid/ready handshake.
// Optional packet counters are enabled by defining NI_STATS_EN.
module mips_network_interface
   import mips_ni_pkg::*;
#(
   parameter logic [1:0] NODE_ID  = 2'd0,
   parameter int         DATA_W   = 32,
   parameter int         TX_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              proc_valid,
   input  logic [1:0]        dest_add,
   input  logic [DATA_W-1:0] NI_in,
   output logic              mips_ni,
   input  logic              proc_ready_in,
   output logic              data_valid,
   output logic [DATA_W-1:0] wd_NI,
   output logic [1:0]        rx_src,
   output logic [DATA_W+1:0] flit_out,
   output logic              flit_out_valid,
   input  logic              flit_out_ready,
   input  logic [DATA_W+1:0] flit_in,
   input  logic              flit_in_valid,
   output logic              flit_in_ready,
   output logic              rx_err
`ifdef NI_STATS_EN
   ,
   output logic [15:0]       tx_pkt_count,
   output logic [15:0]       rx_pkt_count
`endif
);

   // ---------------- TX path ----------------
   logic [DATA_W+1:0]         fifo_rd;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic [$clog2(TX_DEPTH):0] fifo_count;
   logic                      tx_push;
   logic                      tx_pop;
   logic                      tx_more;
   logic [1:0]                tx_state_q, tx_state_d;
   logic [DATA_W-1:0]         head_payload;

   assign mips_ni = !fifo_full;
   assign tx_push = proc_valid && mips_ni;
   assign tx_pop  = (tx_state_q == T_TAIL) && flit_out_ready;
   assign tx_more = (fifo_count > 1) || tx_push;

   ni_tx_fifo #(
      .WIDTH (DATA_W + 2),
      .DEPTH (TX_DEPTH)
   ) u_tx_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (tx_push),
      .wr_data ({dest_add, NI_in}),
      .pop     (tx_pop),
      .rd_data (fifo_rd),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // Head payload carries the queued destination and this node's address
   always_comb begin
      head_payload = '0;
      head_payload[HEAD_DEST_LSB +: NODE_W] = fifo_rd[DATA_W+1:DATA_W];
      head_payload[HEAD_SRC_LSB +: NODE_W]  = NODE_ID;
   end

   // TX sequencing: head then tail per entry, chaining straight into the next entry
   always_comb begin
      tx_state_d     = tx_state_q;
      flit_out_valid = 1'b0;
      flit_out       = '0;
      case (tx_state_q)
         T_IDLE: begin
            if (!fifo_empty) tx_state_d = T_HEAD;
         end
         T_HEAD: begin
            flit_out_valid = 1'b1;
            flit_out       = {FLIT_HEAD, head_payload};
            if (flit_out_ready) tx_state_d = T_TAIL;
         end
         T_TAIL: begin
            flit_out_valid = 1'b1;
            flit_out       = {FLIT_TAIL, fifo_rd[DATA_W-1:0]};
            if (flit_out_ready) tx_state_d = tx_more ? T_HEAD : T_IDLE;
         end
         default: tx_state_d = T_IDLE;
      endcase
   end

   // TX state register
   always_ff @(posedge clk) begin
      if (rst) tx_state_q <= T_IDLE;
      else     tx_state_q <= tx_state_d;
   end

   // ---------------- RX path ----------------
   logic [1:0]        rx_state_q, rx_state_d;
   logic              drop_q, drop_d;
   logic [1:0]        src_q, src_d;
   logic [DATA_W-1:0] wd_q, wd_d;
   logic              err_q, err_d;
   logic              rx_accept;
   logic [1:0]        in_type;
   logic [DATA_W-1:0] in_payload;
   logic              dest_match;

   assign flit_in_ready = (rx_state_q != R_HOLD);
   assign rx_accept     = flit_in_valid && flit_in_ready;
   assign in_type       = flit_in[DATA_W+1:DATA_W];
   assign in_payload    = flit_in[DATA_W-1:0];
   assign dest_match    = (in_payload[HEAD_DEST_LSB +: NODE_W] == NODE_ID);
   assign data_valid    = (rx_state_q == R_HOLD);
   assign wd_NI         = wd_q;
   assign rx_src        = src_q;
   assign rx_err        = err_q;

   // RX reassembly: misaddressed packets are swallowed via the drop flag
   always_comb begin
      rx_state_d = rx_state_q;
      drop_d     = drop_q;
      src_d      = src_q;
      wd_d       = wd_q;
      err_d      = 1'b0;
      case (rx_state_q)
         R_HEAD: begin
            if (rx_accept) begin
               if (in_type == FLIT_HEAD) begin
                  rx_state_d = R_TAIL;
                  if (dest_match) begin
                     src_d  = in_payload[HEAD_SRC_LSB +: NODE_W];
                     drop_d = 1'b0;
                  end else begin
                     drop_d = 1'b1;
                     err_d  = 1'b1;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         R_TAIL: begin
            if (rx_accept) begin
               if (in_type == FLIT_TAIL) begin
                  if (drop_q) begin
                     drop_d     = 1'b0;
                     rx_state_d = R_HEAD;
                  end else begin
                     wd_d       = in_payload;
                     rx_state_d = R_HOLD;
                  end
               end else if (in_type == FLIT_HEAD) begin
                  err_d = 1'b1;
                  if (dest_match) begin
                     src_d  = in_payload[HEAD_SRC_LSB +: NODE_W];
                     drop_d = 1'b0;
                  end else begin
                     drop_d = 1'b1;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         R_HOLD: begin
            if (proc_ready_in) rx_state_d = R_HEAD;
         end
         default: rx_state_d = R_HEAD;
      endcase
   end

   // RX registers
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state_q <= R_HEAD;
         drop_q     <= 1'b0;
         src_q      <= '0;
         wd_q       <= '0;
         err_q      <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         drop_q     <= drop_d;
         src_q      <= src_d;
         wd_q       <= wd_d;
         err_q      <= err_d;
      end
   end

`ifdef NI_STATS_EN
   logic [15:0] tx_cnt_q, tx_cnt_d;
   logic [15:0] rx_cnt_q, rx_cnt_d;

   assign tx_pkt_count = tx_cnt_q;
   assign rx_pkt_count = rx_cnt_q;

   // Packet counters: tail handshakes out and words delivered, wrapping at 16 bits
   always_comb begin
      tx_cnt_d = tx_cnt_q + (tx_pop ? 16'd1 : 16'd0);
      rx_cnt_d = rx_cnt_q + ((data_valid && proc_ready_in) ? 16'd1 : 16'd0);
   end

   // Counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_cnt_q <= '0;
         rx_cnt_q <= '0;
      end else begin
         tx_cnt_q <= tx_cnt_d;
         rx_cnt_q <= rx_cnt_d;
      end
   end
`endif

endmodule

// File: tb/tb_mips_network_interface.sv
// Self-checking bench for mips_network_interface (NODE_ID=1). A cycle-by-cycle
// vector table covers a send, receives and RX error cases; hand-written
// sequences cover TX backpressure/full and reset in mid-packet.
module tb_mips_network_interface;

   logic        clk = 1'b0;
   logic        rst;
   logic        proc_valid;
   logic [1:0]  dest_add;
   logic [31:0] NI_in;
   logic        mips_ni;
   logic        proc_ready_in;
   logic        data_valid;
   logic [31:0] wd_NI;
   logic [1:0]  rx_src;
   logic [33:0] flit_out;
   logic        flit_out_valid;
   logic        flit_out_ready;
   logic [33:0] flit_in;
   logic        flit_in_valid;
   logic        flit_in_ready;
   logic        rx_err;
`ifdef NI_STATS_EN
   logic [15:0] tx_cnt;
   logic [15:0] rx_cnt;
`endif

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic        pv;
      logic [1:0]  dest;
      logic [31:0] data;
      logic        fo_rdy;
      logic [33:0] fin;
      logic        fin_v;
      logic        pr;
      logic        e_fov;
      logic [33:0] e_fo;
      logic        e_ni;
      logic        e_dv;
      logic [31:0] e_wd;
      logic [1:0]  e_src;
      logic        e_fir;
      logic        e_err;
   } vec_t;

   vec_t vecs[21];

   mips_network_interface #(
      .NODE_ID  (2'd1),
      .DATA_W   (32),
      .TX_DEPTH (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .proc_valid     (proc_valid),
      .dest_add       (dest_add),
      .NI_in          (NI_in),
      .mips_ni        (mips_ni),
      .proc_ready_in  (proc_ready_in),
      .data_valid     (data_valid),
      .wd_NI          (wd_NI),
      .rx_src         (rx_src),
      .flit_out       (flit_out),
      .flit_out_valid (flit_out_valid),
      .flit_out_ready (flit_out_ready),
      .flit_in        (flit_in),
      .flit_in_valid  (flit_in_valid),
      .flit_in_ready  (flit_in_ready),
      .rx_err         (rx_err)
`ifdef NI_STATS_EN
      ,
      .tx_pkt_count   (tx_cnt),
      .rx_pkt_count   (rx_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [33:0] hf(input logic [1:0] dest, input logic [1:0] src);
      hf = {2'b01, 28'd0, src, dest};
   endfunction

   function automatic logic [33:0] tf(input logic [31:0] data);
      tf = {2'b10, data};
   endfunction

   function automatic logic [33:0] xf(input logic [1:0] typ, input logic [31:0] data);
      xf = {typ, data};
   endfunction

   function automatic vec_t mkv(
      input logic pv, input logic [1:0] dest, input logic [31:0] data, input logic fo_rdy,
      input logic [33:0] fin, input logic fin_v, input logic pr,
      input logic e_fov, input logic [33:0] e_fo, input logic e_ni, input logic e_dv,
      input logic [31:0] e_wd, input logic [1:0] e_src, input logic e_fir, input logic e_err);
      vec_t v;
      v.pv = pv; v.dest = dest; v.data = data; v.fo_rdy = fo_rdy;
      v.fin = fin; v.fin_v = fin_v; v.pr = pr;
      v.e_fov = e_fov; v.e_fo = e_fo; v.e_ni = e_ni; v.e_dv = e_dv;
      v.e_wd = e_wd; v.e_src = e_src; v.e_fir = e_fir; v.e_err = e_err;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input vec_t v);
      proc_valid     = v.pv;
      dest_add       = v.dest;
      NI_in          = v.data;
      flit_out_ready = v.fo_rdy;
      flit_in        = v.fin;
      flit_in_valid  = v.fin_v;
      proc_ready_in  = v.pr;
   endtask

   task automatic checkOutput(input string name, input int idx,
                              input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic idleInputs();
      proc_valid = 0; dest_add = 0; NI_in = 0; flit_out_ready = 1;
      flit_in = 0; flit_in_valid = 0; proc_ready_in = 0;
   endtask

   task automatic checkResetState(input int idx);
      checkOutput("rst_fov", idx, 64'(flit_out_valid), 64'd0);
      checkOutput("rst_fo", idx, 64'(flit_out), 64'd0);
      checkOutput("rst_ni", idx, 64'(mips_ni), 64'd1);
      checkOutput("rst_dv", idx, 64'(data_valid), 64'd0);
      checkOutput("rst_wd", idx, 64'(wd_NI), 64'd0);
      checkOutput("rst_src", idx, 64'(rx_src), 64'd0);
      checkOutput("rst_fir", idx, 64'(flit_in_ready), 64'd1);
      checkOutput("rst_err", idx, 64'(rx_err), 64'd0);
`ifdef NI_STATS_EN
      checkOutput("rst_txcnt", idx, 64'(tx_cnt), 64'd0);
      checkOutput("rst_rxcnt", idx, 64'(rx_cnt), 64'd0);
`endif
   endtask

   initial begin
      // pv dest data fo_rdy fin fin_v pr | fov fo ni dv wd src fir err
      vecs[0]  = mkv(1, 2, 32'hDEADBEEF, 1, hf(1, 3), 1, 0,  0, 34'd0, 1, 0, 32'd0, 3, 1, 0);
      vecs[1]  = mkv(0, 0, 32'd0, 1, tf(32'h12345678), 1, 0,  1, hf(2, 1), 1, 1, 32'h12345678, 3, 0, 0);
      vecs[2]  = mkv(0, 0, 32'd0, 1, hf(1, 0), 1, 0,  1, tf(32'hDEADBEEF), 1, 1, 32'h12345678, 3, 0, 0);
      vecs[3]  = mkv(0, 0, 32'd0, 1, 34'd0, 0, 0,  0, 34'd0, 1, 1, 32'h12345678, 3, 0, 0);
      vecs[4]  = mkv(0, 0, 32'd0, 1, 34'd0, 0, 1,  0, 34'd0, 1, 0, 32'h12345678, 3, 1, 0);
      vecs[5]  = mkv(0, 0, 32'd0, 1, hf(2, 0), 1, 0,  0, 34'd0, 1, 0, 32'h12345678, 3, 1, 1);
      vecs[6]  = mkv(0, 0, 32'd0, 1, tf(32'hCAFEF00D), 1, 0,  0, 34'd0, 1, 0, 32'h12345678, 3, 1, 0);
      vecs[7]  = mkv(0, 0, 32'd0, 1, tf(32'h11111111), 1, 0,  0, 34'd0, 1, 0, 32'h12345678, 3, 1, 1);
      vecs[8]  = mkv(0, 0, 32'd0, 1, xf(2'b11, 32'd0), 1, 0,  0, 34'd0, 1, 0, 32'h12345678, 3, 1, 1);
      vecs[9]  = mkv(0, 0, 32'd0, 1, 34'd0, 0, 0,  0, 34'd0, 1, 0, 32'h12345678, 3, 1, 0);
      vecs[10] = mkv(0, 0, 32'd0, 1, hf(1, 2), 1, 0,  0, 34'd0, 1, 0, 32'h12345678, 2, 1, 0);
      vecs[11] = mkv(0, 0, 32'd0, 1, hf(1, 0), 1, 0,  0, 34'd0, 1, 0, 32'h12345678, 0, 1, 1);
      vecs[12] = mkv(0, 0, 32'd0, 1, xf(2'b00, 32'd0), 1, 0,  0, 34'd0, 1, 0, 32'h12345678, 0, 1, 1);
      vecs[13] = mkv(0, 0, 32'd0, 1, tf(32'hA5A5A5A5), 1, 0,  0, 34'd0, 1, 1, 32'hA5A5A5A5, 0, 0, 0);
      vecs[14] = mkv(0, 0, 32'd0, 1, 34'd0, 0, 1,  0, 34'd0, 1, 0, 32'hA5A5A5A5, 0, 1, 0);
      vecs[15] = mkv(0, 0, 32'd0, 1, hf(1, 3), 1, 0,  0, 34'd0, 1, 0, 32'hA5A5A5A5, 3, 1, 0);
      vecs[16] = mkv(0, 0, 32'd0, 1, hf(0, 2), 1, 0,  0, 34'd0, 1, 0, 32'hA5A5A5A5, 3, 1, 1);
      vecs[17] = mkv(0, 0, 32'd0, 1, tf(32'hBBBBBBBB), 1, 0,  0, 34'd0, 1, 0, 32'hA5A5A5A5, 3, 1, 0);
      vecs[18] = mkv(0, 0, 32'd0, 1, hf(1, 1), 1, 0,  0, 34'd0, 1, 0, 32'hA5A5A5A5, 1, 1, 0);
      vecs[19] = mkv(0, 0, 32'd0, 1, tf(32'h0F0F0F0F), 1, 0,  0, 34'd0, 1, 1, 32'h0F0F0F0F, 1, 0, 0);
      vecs[20] = mkv(0, 0, 32'd0, 1, 34'd0, 0, 1,  0, 34'd0, 1, 0, 32'h0F0F0F0F, 1, 1, 0);

      // Reset
      idleInputs();
      rst = 1;
      tick();
      tick();
      checkResetState(0);
      rst = 0;

      // Table: single send with concurrent receive, then RX error handling
      for (int i = 0; i < 21; i++) begin
         applyStimulus(vecs[i]);
         tick();
         checkOutput("fov", i, 64'(flit_out_valid), 64'(vecs[i].e_fov));
         checkOutput("fo", i, 64'(flit_out), 64'(vecs[i].e_fo));
         checkOutput("ni", i, 64'(mips_ni), 64'(vecs[i].e_ni));
         checkOutput("dv", i, 64'(data_valid), 64'(vecs[i].e_dv));
         checkOutput("wd", i, 64'(wd_NI), 64'(vecs[i].e_wd));
         checkOutput("src", i, 64'(rx_src), 64'(vecs[i].e_src));
         checkOutput("fir", i, 64'(flit_in_ready), 64'(vecs[i].e_fir));
         checkOutput("err", i, 64'(rx_err), 64'(vecs[i].e_err));
      end
      idleInputs();

      // Backpressure: five sends while the router stalls; the fifth is refused
      flit_out_ready = 0;
      for (int i = 0; i < 5; i++) begin
         proc_valid = 1;
         dest_add   = 2'(i);
         NI_in      = 32'hB0000000 + 32'(i);
         tick();
         checkOutput("full_ni", i, 64'(mips_ni), (i < 3) ? 64'd1 : 64'd0);
      end
      proc_valid = 0;
      for (int i = 0; i < 3; i++) begin
         checkOutput("stall_fov", i, 64'(flit_out_valid), 64'd1);
         checkOutput("stall_fo", i, 64'(flit_out), 64'(hf(2'd0, 2'd1)));
         tick();
      end
      flit_out_ready = 1;
      for (int k = 0; k < 8; k++) begin
         checkOutput("drain_fov", k, 64'(flit_out_valid), 64'd1);
         checkOutput("drain_fo", k, 64'(flit_out),
                     (k % 2 == 0) ? 64'(hf(2'(k / 2), 2'd1))
                                  : 64'(tf(32'hB0000000 + 32'(k / 2))));
         tick();
      end
      checkOutput("drained_fov", 0, 64'(flit_out_valid), 64'd0);
      checkOutput("drained_fo", 0, 64'(flit_out), 64'd0);
      checkOutput("drained_ni", 0, 64'(mips_ni), 64'd1);
`ifdef NI_STATS_EN
      checkOutput("txcnt", 0, 64'(tx_cnt), 64'd5);
      checkOutput("rxcnt", 0, 64'(rx_cnt), 64'd3);
`endif

      // Reset mid-packet: TX in tail with 2 entries queued, RX waiting for a tail
      flit_out_ready = 0;
      proc_valid = 1; dest_add = 3; NI_in = 32'h55;
      flit_in = hf(1, 2); flit_in_valid = 1;
      tick();
      proc_valid = 1; dest_add = 0; NI_in = 32'h66;
      flit_in_valid = 0;
      tick();
      proc_valid = 0;
      flit_out_ready = 1;
      tick();
      flit_out_ready = 0;
      checkOutput("pre_rst_fov", 0, 64'(flit_out_valid), 64'd1);
      checkOutput("pre_rst_fo", 0, 64'(flit_out), 64'(tf(32'h55)));
      rst = 1;
      tick();
      rst = 0;
      checkResetState(1);
      flit_out_ready = 1;
      tick();
      checkOutput("post_rst_fov", 0, 64'(flit_out_valid), 64'd0);
      checkOutput("post_rst_ni", 0, 64'(mips_ni), 64'd1);
      flit_in = tf(32'h77777777); flit_in_valid = 1;
      tick();
      flit_in_valid = 0;
      checkOutput("post_rst_err", 0, 64'(rx_err), 64'd1);
      checkOutput("post_rst_dv", 0, 64'(data_valid), 64'd0);
      tick();
      checkOutput("post_rst_err_clr", 0, 64'(rx_err), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
